xbus_arbiter: RTL and testbench
===============================

// Module: xbus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one sel/ack memory bus between NUM_MASTERS requesters
//  (CPU core, DMA, video fetch). Sits between the masters and the memory/peripheral
//  decoder. Latches the winner's request, drives the downstream bus and returns the
//  slave response to that master only.
// PARAMETERS
//  NUM_MASTERS     3    number of requesters, 2..8
//  TIMEOUT_CYCLES  256  watchdog limit in cycles; used only with XBUS_TIMEOUT_EN
// PORTS
//  clk           in   1        system clock, rising edge
//  reset_i       in   1        asynchronous, active-high reset
//  m_sel_i       in   N        per-master request; held high until its m_ack_o pulse
//  m_addr_i      in   N*32     per-master byte address, master k at [32k+:32]
//  m_we_i        in   N        per-master write enable
//  m_wr_mask_i   in   N*4      per-master byte-lane write mask
//  m_data_i      in   N*32     per-master write data
//  m_ack_o       out  N        one-cycle completion pulse to the granted master
//  m_data_o      out  32       read data, shared; valid only while m_ack_o[k]=1
//  m_fault_o     out  1        pulses with m_ack_o when the access timed out
//  sel_o         out  1        downstream request, held until ack_i
//  addr_o        out  32       downstream address, registered
//  we_o          out  1        downstream write enable, registered
//  wr_mask_o     out  4        downstream write mask, registered
//  data_out_o    out  32       downstream write data, registered
//  data_in_i     in   32       downstream read data, valid with ack_i
//  ack_i         in   1        downstream completion, one cycle
// BEHAVIOUR
//  - Reset: state=IDLE; sel_o, we_o, m_ack_o, m_fault_o = 0; addr_o, wr_mask_o,
//    data_out_o, m_data_o = 0; last_grant = NUM_MASTERS-1, so master 0 wins first.
//  - FSM IDLE -> BUSY -> ACK -> IDLE.
//  - IDLE: if any m_sel_i bit is set, scan from last_grant+1 mod N upward with
//    wrap. The first set bit wins: grant=k, last_grant=k. Latch addr/we/mask/data
//    of k into the downstream registers. sel_o=1 on the next cycle. State=BUSY.
//  - BUSY: hold sel_o and all downstream outputs stable. Ignore m_sel_i changes.
//    On ack_i: sel_o<=0, m_data_o<=data_in_i, state=ACK.
//  - ACK: m_ack_o[grant]=1 for exactly this cycle. No arbitration in this cycle, so
//    the master can drop m_sel_i. State=IDLE.
//  - Latency: request sampled at edge t gives sel_o high after t. ack_i at edge u
//    gives m_ack_o high in cycle u+1. Minimum occupancy is 3 cycles per access.
//  - Simultaneous requests: round-robin only. No master wins twice while another is
//    waiting.
//  - ack_i outside BUSY is ignored. It must not produce m_ack_o.
//  - A master that drops m_sel_i before its ack does not abort the access. Its
//    ack is still pulsed.
//  - Asynchronous reset mid-access: the bus drops at once and the access is lost.
//    No ack is issued.
//  - m_fault_o is always 0 unless XBUS_TIMEOUT_EN is defined.
// CONFIGURATION
//  XBUS_TIMEOUT_EN defined: a counter clears on entry to BUSY and increments each
//   BUSY cycle. When it reaches TIMEOUT_CYCLES without ack_i:
//   - sel_o<=0 and m_data_o<=32'hDEADBEEF
//   - state=ACK, and m_fault_o pulses with m_ack_o
//   - if ack_i arrives on that same edge, the ack wins and there is no fault.
//  Not defined: no counter. BUSY waits for ack_i indefinitely. m_fault_o is tied 0.
// TESTING
//  1 Single read: m0 reads 0x1000, slave acks after 2 cycles with 0xCAFEF00D ->
//    sel_o for 3 cycles, m_ack_o=001 one cycle, m_data_o=0xCAFEF00D.
//  2 Contention: m0,m1,m2 all request after reset -> grant order 0,1,2. With all
//    three held constantly, the order repeats 0,1,2,0.
//  3 Write: m1 writes 0x55AA1234 to 0x2004, mask 4'b0011 ->
//    addr_o=0x2004, we_o=1, wr_mask_o=0011, data_out_o stable until ack.
//  4 Stray ack: ack_i pulsed while IDLE -> m_ack_o stays 0 and the FSM stays IDLE.
//  5 Reset mid-access: assert reset_i while BUSY -> sel_o=0 immediately. After
//    release, master 0 has priority again.
//  6 With XBUS_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no slave ack ->
//    after 16 BUSY cycles: m_ack_o pulses, m_fault_o=1, m_data_o=0xDEADBEEF.

Source files
------------

// File: rtl/xbus_if.sv
// Bundle of all master-side and downstream bus signals around xbus_arbiter.
// The arbiter uses the slave modport; the masters/memory environment uses master.
interface xbus_if #(
    parameter int NUM_MASTERS = 3
);
    logic [NUM_MASTERS-1:0]    m_sel_i;
    logic [NUM_MASTERS*32-1:0] m_addr_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS*4-1:0]  m_wr_mask_i;
    logic [NUM_MASTERS*32-1:0] m_data_i;
    logic [NUM_MASTERS-1:0]    m_ack_o;
    logic [31:0]               m_data_o;
    logic                      m_fault_o;
    logic                      sel_o;
    logic [31:0]               addr_o;
    logic                      we_o;
    logic [3:0]                wr_mask_o;
    logic [31:0]               data_out_o;
    logic [31:0]               data_in_i;
    logic                      ack_i;

    modport slave (
        input  m_sel_i, m_addr_i, m_we_i, m_wr_mask_i, m_data_i, data_in_i, ack_i,
        output m_ack_o, m_data_o, m_fault_o, sel_o, addr_o, we_o, wr_mask_o, data_out_o
    );

    modport master (
        output m_sel_i, m_addr_i, m_we_i, m_wr_mask_i, m_data_i, data_in_i, ack_i,
        input  m_ack_o, m_data_o, m_fault_o, sel_o, addr_o, we_o, wr_mask_o, data_out_o
    );
endinterface

// File: rtl/xbus_arbiter.sv
// Round-robin arbiter sharing one sel/ack memory bus among NUM_MASTERS requesters.
// Define XBUS_TIMEOUT_EN to add a BUSY watchdog that faults after TIMEOUT_CYCLES.
module xbus_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic  clk,
    input  logic  reset_i,
    xbus_if.slave bus
);
    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] { IDLE, BUSY, ACK } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic                   sel_q, sel_d;
    logic [31:0]            addr_q, addr_d;
    logic                   we_q, we_d;
    logic [3:0]             mask_q, mask_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [NUM_MASTERS-1:0] ack_q, ack_d;

`ifdef XBUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   fault_q, fault_d;
`endif

    logic                   win_found;
    logic [GW-1:0]          win_idx;
    int                     cand;
    logic [31:0]            win_addr;
    logic                   win_we;
    logic [3:0]             win_mask;
    logic [31:0]            win_wdata;

    // Rotating priority: the master after the last grant is looked at first.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(grant_q) + i;
            if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
            if (!win_found && bus.m_sel_i[GW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = GW'(cand);
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_mask  = '0;
        win_wdata = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (win_idx == GW'(k)) begin
                win_addr  = bus.m_addr_i[32*k +: 32];
                win_we    = bus.m_we_i[k];
                win_mask  = bus.m_wr_mask_i[4*k +: 4];
                win_wdata = bus.m_data_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        we_d    = we_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = '0;
`ifdef XBUS_TIMEOUT_EN
        cnt_d   = cnt_q;
        fault_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    addr_d  = win_addr;
                    we_d    = win_we;
                    mask_d  = win_mask;
                    wdata_d = win_wdata;
                    sel_d   = 1'b1;
                    state_d = BUSY;
`ifdef XBUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (bus.ack_i) begin
                    sel_d          = 1'b0;
                    rdata_d        = bus.data_in_i;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ACK;
                end
`ifdef XBUS_TIMEOUT_EN
                // A slave ack on the expiry edge takes precedence over the fault.
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    sel_d          = 1'b0;
                    rdata_d        = 32'hDEADBEEF;
                    ack_d[grant_q] = 1'b1;
                    fault_d        = 1'b1;
                    state_d        = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= GW'(NUM_MASTERS - 1);
            sel_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
`ifdef XBUS_TIMEOUT_EN
            cnt_q   <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
`ifdef XBUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign bus.sel_o      = sel_q;
    assign bus.addr_o     = addr_q;
    assign bus.we_o       = we_q;
    assign bus.wr_mask_o  = mask_q;
    assign bus.data_out_o = wdata_q;
    assign bus.m_data_o   = rdata_q;
    assign bus.m_ack_o    = ack_q;
`ifdef XBUS_TIMEOUT_EN
    assign bus.m_fault_o  = fault_q;
`else
    assign bus.m_fault_o  = 1'b0;
`endif
endmodule

// File: tb/tb_xbus_arbiter.sv
// Testbench for xbus_arbiter: vector table, hand-written corner sequences and
// randomized transactions checked against a round-robin reference model.
module tb_xbus_arbiter;
  localparam int NM  = 3;
  localparam int TMO = 16;

  typedef struct {
    logic [NM-1:0] req;
    int            dly;
    logic [31:0]   rdata;
    int            exp_g;
  } vec_t;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  xbus_if #(.NUM_MASTERS(NM)) bus ();

  xbus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          model_last;
  logic [31:0] addr_v [NM];
  logic [31:0] wd_v   [NM];
  logic [3:0]  mask_v [NM];
  logic        we_v   [NM];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply();
    for (int k = 0; k < NM; k++) begin
      bus.m_addr_i[32*k +: 32]  = addr_v[k];
      bus.m_data_i[32*k +: 32]  = wd_v[k];
      bus.m_wr_mask_i[4*k +: 4] = mask_v[k];
      bus.m_we_i[k]             = we_v[k];
    end
  endtask

  task automatic randomize_masters();
    for (int k = 0; k < NM; k++) begin
      addr_v[k] = $urandom;
      wd_v[k]   = $urandom;
      mask_v[k] = 4'($urandom_range(0, 15));
      we_v[k]   = 1'($urandom_range(0, 1));
    end
    apply();
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NM; k++) begin
      addr_v[k] = '0; wd_v[k] = '0; mask_v[k] = '0; we_v[k] = 1'b0;
    end
    apply();
    bus.m_sel_i   = '0;
    bus.ack_i     = 1'b0;
    bus.data_in_i = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset_i    = 1'b0;
    model_last = NM - 1;
  endtask

  // Reference rule: scan from the master after the last winner, wrapping around.
  function automatic int rr_pick(input int last, input logic [NM-1:0] req);
    int r;
    int c;
    r = int'(req);
    for (int i = 1; i <= NM; i++) begin
      c = (last + i) % NM;
      if (((r >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  // Starts and ends on a negedge with the arbiter idle.
  task automatic run_txn(input logic [NM-1:0] req, input int dly, input logic [31:0] rdata,
                         input bit scramble, output int gnt);
    int          exp_g;
    int          waited;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_mask;
    logic        e_we;
    gnt   = -1;
    exp_g = rr_pick(model_last, req);
    apply();
    bus.m_sel_i = req;
    if (exp_g < 0) begin
      tick();
      chk("no_req_sel", 32'(bus.sel_o), 32'd0);
      chk("no_req_ack", 32'(bus.m_ack_o), 32'd0);
      return;
    end
    e_addr = addr_v[exp_g];
    e_wd   = wd_v[exp_g];
    e_mask = mask_v[exp_g];
    e_we   = we_v[exp_g];
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!bus.sel_o && waited < 50);
    chk("req_to_sel_latency", 32'(waited), 32'd1);
    if (!bus.sel_o) begin
      bus.m_sel_i = '0;
      return;
    end
    model_last = exp_g;
    for (int d = 0; d <= dly; d++) begin
      chk("busy_sel", 32'(bus.sel_o), 32'd1);
      chk("busy_addr", bus.addr_o, e_addr);
      chk("busy_we", 32'(bus.we_o), 32'(e_we));
      chk("busy_mask", 32'(bus.wr_mask_o), 32'(e_mask));
      chk("busy_wdata", bus.data_out_o, e_wd);
      chk("busy_no_ack", 32'(bus.m_ack_o), 32'd0);
      if (scramble) begin
        randomize_masters();
        bus.m_sel_i = NM'($urandom_range(0, (1 << NM) - 1));
      end
      bus.data_in_i = (d == dly) ? rdata : $urandom;
      bus.ack_i     = (d == dly);
      tick();
    end
    bus.ack_i = 1'b0;
    chk("ack_sel_dropped", 32'(bus.sel_o), 32'd0);
    chk("ack_onehot", 32'(bus.m_ack_o), 32'd1 << exp_g);
    chk("ack_rdata", bus.m_data_o, rdata);
    chk("ack_no_fault", 32'(bus.m_fault_o), 32'd0);
    for (int k = 0; k < NM; k++)
      if (32'(bus.m_ack_o) == (32'd1 << k)) gnt = k;
    bus.m_sel_i = '0;
    tick();
    chk("ack_one_cycle", 32'(bus.m_ack_o), 32'd0);
  endtask

  task automatic stray_ack();
    bus.ack_i     = 1'b1;
    bus.data_in_i = $urandom;
    tick();
    bus.ack_i = 1'b0;
    chk("stray_no_ack", 32'(bus.m_ack_o), 32'd0);
    chk("stray_no_sel", 32'(bus.sel_o), 32'd0);
    tick();
    chk("stray_no_ack_late", 32'(bus.m_ack_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [11];
    int   exp_order [4];
    int   g;
    int   w;
    int   cnt;

    vt[0]  = '{3'b001, 2, 32'hCAFEF00D, 0};
    vt[1]  = '{3'b111, 0, 32'h11110001, 1};
    vt[2]  = '{3'b111, 1, 32'h22220002, 2};
    vt[3]  = '{3'b111, 3, 32'h33330003, 0};
    vt[4]  = '{3'b110, 0, 32'h44440004, 1};
    vt[5]  = '{3'b101, 2, 32'h55550005, 2};
    vt[6]  = '{3'b011, 1, 32'h66660006, 0};
    vt[7]  = '{3'b100, 0, 32'h77770007, 2};
    vt[8]  = '{3'b101, 4, 32'h88880008, 0};
    vt[9]  = '{3'b010, 0, 32'h99990009, 1};
    vt[10] = '{3'b000, 0, 32'h00000000, -1};
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 0;

    reset_i = 1'b1;
    clear_inputs();
    #2;
    chk("rst_sel", 32'(bus.sel_o), 32'd0);
    chk("rst_we", 32'(bus.we_o), 32'd0);
    chk("rst_ack", 32'(bus.m_ack_o), 32'd0);
    chk("rst_fault", 32'(bus.m_fault_o), 32'd0);
    chk("rst_addr", bus.addr_o, 32'd0);
    chk("rst_mask", 32'(bus.wr_mask_o), 32'd0);
    chk("rst_wdata", bus.data_out_o, 32'd0);
    chk("rst_rdata", bus.m_data_o, 32'd0);
    do_reset();

    // Vector table: grants chained from reset, first entry is the single read.
    for (int k = 0; k < NM; k++) addr_v[k] = 32'h1000 + 32'(k) * 32'h10;
    for (int i = 0; i < 11; i++) begin
      run_txn(vt[i].req, vt[i].dly, vt[i].rdata, 1'b0, g);
      chk($sformatf("table_grant_%0d", i), 32'(g), 32'(vt[i].exp_g));
    end

    // All three masters held constantly.
    do_reset();
    bus.m_sel_i = 3'b111;
    for (int r = 0; r < 4; r++) begin
      w = 0;
      while (!bus.sel_o && w < 20) begin tick(); w++; end
      chk("contend_sel_seen", 32'(bus.sel_o), 32'd1);
      bus.ack_i     = 1'b1;
      bus.data_in_i = 32'(r);
      tick();
      bus.ack_i = 1'b0;
      chk($sformatf("contend_grant_%0d", r), 32'(bus.m_ack_o), 32'd1 << exp_order[r]);
    end
    bus.m_sel_i = '0;
    tick();

    // Master 1 write.
    do_reset();
    addr_v[1] = 32'h2004; wd_v[1] = 32'h55AA1234; mask_v[1] = 4'b0011; we_v[1] = 1'b1;
    run_txn(3'b010, 3, 32'h0, 1'b0, g);
    chk("write_grant", 32'(g), 32'd1);

    // Stray ack while idle, then a normal access must still start in one cycle.
    stray_ack();
    addr_v[0] = 32'h3000; we_v[0] = 1'b0;
    run_txn(3'b001, 1, 32'hA5A5A5A5, 1'b0, g);
    chk("after_stray_grant", 32'(g), 32'd0);

    // Asynchronous reset while BUSY.
    do_reset();
    bus.m_sel_i = 3'b010;
    tick();
    chk("rstmid_busy", 32'(bus.sel_o), 32'd1);
    #2;
    reset_i   = 1'b1;
    bus.ack_i = 1'b1;
    #1;
    chk("rstmid_sel_drop", 32'(bus.sel_o), 32'd0);
    chk("rstmid_addr_clr", bus.addr_o, 32'd0);
    tick();
    tick();
    chk("rstmid_no_ack", 32'(bus.m_ack_o), 32'd0);
    reset_i     = 1'b0;
    bus.ack_i   = 1'b0;
    bus.m_sel_i = '0;
    model_last  = NM - 1;
    tick();
    chk("rstmid_no_ack_after", 32'(bus.m_ack_o), 32'd0);
    run_txn(3'b111, 0, 32'h0BADF00D, 1'b0, g);
    chk("rstmid_m0_priority", 32'(g), 32'd0);

`ifdef XBUS_TIMEOUT_EN
    do_reset();
    bus.m_sel_i = 3'b001;
    tick();
    cnt = 0;
    while (bus.sel_o && cnt < 100) begin cnt++; tick(); end
    chk("tmo_busy_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_ack", 32'(bus.m_ack_o), 32'd1);
    chk("tmo_fault", 32'(bus.m_fault_o), 32'd1);
    chk("tmo_rdata", bus.m_data_o, 32'hDEADBEEF);
    bus.m_sel_i = '0;
    tick();
    chk("tmo_fault_pulse", 32'(bus.m_fault_o), 32'd0);
    chk("tmo_ack_pulse", 32'(bus.m_ack_o), 32'd0);
    bus.m_sel_i = 3'b001;
    tick();
    repeat (TMO - 1) tick();
    chk("tie_still_busy", 32'(bus.sel_o), 32'd1);
    bus.ack_i     = 1'b1;
    bus.data_in_i = 32'h12345678;
    tick();
    bus.ack_i = 1'b0;
    chk("tie_ack", 32'(bus.m_ack_o), 32'd1);
    chk("tie_no_fault", 32'(bus.m_fault_o), 32'd0);
    chk("tie_rdata", bus.m_data_o, 32'h12345678);
    bus.m_sel_i = '0;
    tick();
    tick();
`else
    do_reset();
    bus.m_sel_i = 3'b001;
    tick();
    cnt = 0;
    while (bus.sel_o && cnt < 40) begin cnt++; tick(); end
    chk("notmo_still_busy", 32'(cnt), 32'd40);
    chk("notmo_no_ack", 32'(bus.m_ack_o), 32'd0);
    chk("notmo_no_fault", 32'(bus.m_fault_o), 32'd0);
    bus.ack_i     = 1'b1;
    bus.data_in_i = 32'h0F0F0F0F;
    tick();
    bus.ack_i = 1'b0;
    chk("notmo_late_ack", 32'(bus.m_ack_o), 32'd1);
    chk("notmo_rdata", bus.m_data_o, 32'h0F0F0F0F);
    bus.m_sel_i = '0;
    tick();
`endif

    // Randomized traffic against the round-robin model.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) stray_ack();
      randomize_masters();
      run_txn(NM'($urandom_range(0, (1 << NM) - 1)), int'($urandom_range(0, 5)),
              $urandom, 1'($urandom_range(0, 1)), g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
